// File: rtl/rr_bit_scheduler.sv
// Round-robin grant scheduler: picks the lowest requester at or above a rotating pointer
// and offers it as index plus one-hot on a valid/ready handshake, one grant per cycle.
module rr_bit_scheduler #(
    parameter int N    = 24,
    parameter int IDXW = $clog2(N),
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_l,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            gnt_ready,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot,
    output logic [CNTW-1:0] gnt_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [N-1:0]    OH_ONE   = N'(1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
    logic [CNTW-1:0] gnt_count_q, gnt_count_d;

    logic            accept_s;
    logic            any_s;
    logic [IDXW-1:0] ptr_nxt_s;
    logic [IDXW-1:0] search_ptr_s;
    logic [IDXW-1:0] hi_idx_s;
    logic            hi_found_s;
    logic [IDXW-1:0] lo_idx_s;
    logic [IDXW-1:0] cand_s;

    assign accept_s  = (state_q == ST_GRANT) && gnt_ready;
    assign any_s     = |req;
    assign ptr_nxt_s = (gnt_idx_q == LAST_IDX) ? {IDXW{1'b0}} : (gnt_idx_q + IDX_ONE);
    // On an accept the search already uses the post-accept pointer so back-to-back grants rotate.
    assign search_ptr_s = accept_s ? ptr_nxt_s : ptr_q;

    // Candidate search: lowest set bit at/above the pointer, else lowest set bit overall.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = {IDXW{1'b0}};
        lo_idx_s   = {IDXW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx_s = IDXW'(i);
                if (IDXW'(i) >= search_ptr_s) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = IDXW'(i);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                lo_idx_s = lo_idx_s;
            end
        end
        cand_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Next-state and grant register logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_count_d  = gnt_count_q;
        case (state_q)
            ST_IDLE: begin
                if (en && any_s) begin
                    state_d      = ST_GRANT;
                    gnt_idx_d    = cand_s;
                    gnt_onehot_d = OH_ONE << cand_s;
                end else begin
                    state_d      = ST_IDLE;
                    gnt_onehot_d = {N{1'b0}};
                end
            end
            ST_GRANT: begin
                if (gnt_ready) begin
                    gnt_count_d = gnt_count_q + CNT_ONE;
                    ptr_d       = ptr_nxt_s;
                    if (en && any_s) begin
                        state_d      = ST_GRANT;
                        gnt_idx_d    = cand_s;
                        gnt_onehot_d = OH_ONE << cand_s;
                    end else begin
                        state_d      = ST_IDLE;
                        gnt_onehot_d = {N{1'b0}};
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                gnt_onehot_d = {N{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {IDXW{1'b0}};
            gnt_idx_q    <= {IDXW{1'b0}};
            gnt_onehot_q <= {N{1'b0}};
            gnt_count_q  <= {CNTW{1'b0}};
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_count_q  <= gnt_count_d;
        end
    end

    assign gnt_valid  = (state_q == ST_GRANT);
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_count  = gnt_count_q;

endmodule

// File: tb/tb_rr_bit_scheduler.sv
// Directed bench for rr_bit_scheduler: reset, rotation, hold, wrap, enable gating
// and asynchronous reset in the middle of a grant.
module tb_rr_bit_scheduler;

    localparam int N    = 24;
    localparam int IDXW = 5;
    localparam int CNTW = 16;

    logic            clk;
    logic            reset_l;
    logic            en;
    logic [N-1:0]    req;
    logic            gnt_ready;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;
    logic [CNTW-1:0] gnt_count;

    int checks_r;
    int errors_r;

    rr_bit_scheduler #(.N(N), .IDXW(IDXW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .en         (en),
        .req        (req),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .gnt_count  (gnt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_l   = 1'b0;
        en        = 1'b0;
        req       = 24'h000000;
        gnt_ready = 1'b0;
        tick();
        tick();
        reset_l = 1'b1;
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;

        // 1: reset state then single requester
        do_reset();
        check_eq("rst_valid",  32'(gnt_valid),  32'd0);
        check_eq("rst_idx",    32'(gnt_idx),    32'd0);
        check_eq("rst_onehot", 32'(gnt_onehot), 32'd0);
        check_eq("rst_count",  32'(gnt_count),  32'd0);
        en = 1'b1; req = 24'h000001; gnt_ready = 1'b1;
        tick();
        check_eq("t1_valid",  32'(gnt_valid),  32'd1);
        check_eq("t1_idx",    32'(gnt_idx),    32'd0);
        check_eq("t1_onehot", 32'(gnt_onehot), 32'h000001);
        tick();
        check_eq("t1_count",  32'(gnt_count),  32'd1);
        check_eq("t1_regrant_idx", 32'(gnt_idx), 32'd0);
        check_eq("t1_regrant_vld", 32'(gnt_valid), 32'd1);

        // 2: full rotation with ready held
        do_reset();
        en = 1'b1; req = 24'hFFFFFF; gnt_ready = 1'b1;
        for (int k = 0; k < 26; k++) begin
            tick();
            check_eq("t2_idx",    32'(gnt_idx),    32'(k % 24));
            check_eq("t2_onehot", 32'(gnt_onehot), 32'h1 << (k % 24));
        end
        check_eq("t2_count", 32'(gnt_count), 32'd25);

        // 3: hold under backpressure, no revoke on request drop
        do_reset();
        en = 1'b1; req = 24'h800010; gnt_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_eq("t3_hold_idx", 32'(gnt_idx), 32'd4);
            tick();
        end
        req = 24'h800000;
        tick();
        check_eq("t3_drop_idx",   32'(gnt_idx),   32'd4);
        check_eq("t3_drop_valid", 32'(gnt_valid), 32'd1);
        en = 1'b0;
        tick();
        check_eq("t3_en0_valid",  32'(gnt_valid), 32'd1);
        en = 1'b1; gnt_ready = 1'b1;
        tick();
        check_eq("t3_next_idx",   32'(gnt_idx),   32'd23);
        check_eq("t3_count",      32'(gnt_count), 32'd1);
        gnt_ready = 1'b0;

        // 4: pointer wrap after accepting idx 8
        do_reset();
        en = 1'b1; req = 24'h000100; gnt_ready = 1'b0;
        tick();
        check_eq("t4_first_idx", 32'(gnt_idx), 32'd8);
        req = 24'h000101; gnt_ready = 1'b1;
        tick();
        check_eq("t4_wrap_idx",    32'(gnt_idx),    32'd0);
        check_eq("t4_wrap_onehot", 32'(gnt_onehot), 32'h000001);
        req = 24'h000000;
        tick();
        check_eq("t4_idle_valid",  32'(gnt_valid),  32'd0);
        check_eq("t4_idle_onehot", 32'(gnt_onehot), 32'd0);
        check_eq("t4_count",       32'(gnt_count),  32'd2);

        // 5: enable gating
        do_reset();
        en = 1'b0; req = 24'h000040; gnt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t5_en0_valid", 32'(gnt_valid), 32'd0);
        end
        en = 1'b1;
        tick();
        check_eq("t5_valid",  32'(gnt_valid),  32'd1);
        check_eq("t5_idx",    32'(gnt_idx),    32'd6);
        check_eq("t5_onehot", 32'(gnt_onehot), 32'h000040);

        // 6: asynchronous reset between clock edges
        do_reset();
        en = 1'b1; req = 24'hFFFFFF; gnt_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t6_pre_idx",   32'(gnt_idx),   32'd2);
        check_eq("t6_pre_count", 32'(gnt_count), 32'd2);
        #2;
        reset_l = 1'b0;
        #1;
        check_eq("t6_async_valid",  32'(gnt_valid),  32'd0);
        check_eq("t6_async_onehot", 32'(gnt_onehot), 32'd0);
        check_eq("t6_async_count",  32'(gnt_count),  32'd0);
        #4;
        reset_l = 1'b1;
        tick();
        check_eq("t6_restart_idx",   32'(gnt_idx),   32'd0);
        check_eq("t6_restart_valid", 32'(gnt_valid), 32'd1);
        tick();
        check_eq("t6_second_idx",    32'(gnt_idx),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
